// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked byte-enabled data memory for the LSU.
// One request in flight at a time. Errors (illegal funct3, misaligned,
// out of range) are resolved at accept and never touch the array.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The requester holds req_* stable until req_ready is seen. The
// controller holds rsp_* stable from rsp_valid rising until rsp_ready.
module data_mem_ctrl #(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          READ_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [1:0]       rsp_err,
    output logic [1:0]       dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lat_data;
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [29:0]      off_word;
    logic [AW-1:0]    widx;
    logic             oor;
    logic             f3_bad;
    logic             misal;
    logic [1:0]       err_c;
    logic [WIDTH-1:0] rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] ext;
    logic [3:0]       be;
    logic [WIDTH-1:0] wd;
    logic             accept;

    assign req_ready = (state == IDLE);
    assign dbg_state = state;
    assign accept    = req_valid && req_ready;

    // Word-level offset avoids touching the byte bits; BASE_ADDR is word aligned,
    // and a wrapped (below-base) address lands far above DEPTH.
    assign off_word = req_addr[31:2] - BASE_ADDR[31:2];
    assign widx     = off_word[AW-1:0];
    assign oor      = |off_word[29:AW];
    assign rd_word  = mem[widx];

    // Decode error class, lane extraction and store byte enables.
    always_comb begin
        f3_bad  = req_we ? (req_funct3 > 3'd2)
                         : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misal   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                  (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        err_c   = 2'b00;
        if (f3_bad)     err_c = 2'b11;
        else if (misal) err_c = 2'b01;
        else if (oor)   err_c = 2'b10;

        rd_byte = rd_word[7:0];
        case (req_addr[1:0])
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            2'd3:    rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

        ext = '0;
        case (req_funct3)
            3'b000:  ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  ext = rd_word;
            3'b100:  ext = {24'd0, rd_byte};
            3'b101:  ext = {16'd0, rd_half};
            default: ext = '0;
        endcase

        be = 4'b0000;
        wd = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be = 4'b0001 << req_addr[1:0];
                wd = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be = req_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                be = 4'b1111;
                wd = req_wdata;
            end
            default: begin
                be = 4'b0000;
                wd = req_wdata;
            end
        endcase
    end

    // Byte-enabled store on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && err_c == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 2'b00;
            lat_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rsp_err <= err_c;
                        if (err_c != 2'b00 || req_we) begin
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (READ_LAT == 2) begin
                            lat_data <= ext;
                            state    <= WAIT;
                        end else begin
                            rsp_rdata <= ext;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    rsp_rdata <= lat_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl. Two instances share the request stimulus:
// A = base 0, 1024 words, latency 1; B = base 0x1000, 16 words, latency 2.
// sel picks which instance sees req_valid/rsp_ready and whose outputs are observed.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;

    logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic [1:0]  a_rsp_err, b_rsp_err, a_dbg, b_dbg;

    logic        req_ready_o, rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_err_o, dbg_o;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1;

    // Clock generation.
    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .dbg_state(a_dbg)
    );

    data_mem_ctrl #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .dbg_state(b_dbg)
    );

    assign req_ready_o = sel ? b_req_ready : a_req_ready;
    assign rsp_valid_o = sel ? b_rsp_valid : a_rsp_valid;
    assign rsp_rdata_o = sel ? b_rsp_rdata : a_rsp_rdata;
    assign rsp_err_o   = sel ? b_rsp_err   : a_rsp_err;
    assign dbg_o       = sel ? b_dbg       : a_dbg;

    // Driver: one full request/response with rsp_ready high; returns data, error and
    // latency in cycles from the accept edge to rsp_valid seen.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, output logic [31:0] rdata,
                          output logic [1:0] err, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_funct3 = f3; rsp_ready = 1'b1;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            tests_run++; tests_failed++;
            $display("FAIL req_timeout: addr %h not accepted in 20 cycles", addr);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        rdata = 32'hx; err = 2'bxx;
        while (lat < 20) begin
            @(negedge clk); lat++;
            if (rsp_valid_o) break;
        end
        if (!rsp_valid_o) begin
            tests_run++; tests_failed++;
            $display("FAIL rsp_timeout: addr %h no response in 20 cycles", addr);
        end
        rdata = rsp_rdata_o; err = rsp_err_o;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            tests_run++;
            if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'd0 || rsp_err_o !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got valid=%b rdata=%h err=%b required 0/0/00",
                         s, rsp_valid_o, rsp_rdata_o, rsp_err_o);
            end
        end
        sel = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || a_dbg !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_ready: got a=%b b=%b state=%0d required 1/1/0",
                     a_req_ready, b_req_ready, a_dbg);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic [1:0] er; int lat;
        sel = 1'b0;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 2'b00 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL sw_basic: got lat=%0d err=%b rdata=%h required 1/00/0", lat, er, rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (lat !== 1 || er !== 2'b00 || rd !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL lw_basic: got lat=%0d err=%b rdata=%h required 1/00/deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic [1:0] er; int lat;
        sel = 1'b0;
        do_req(1'b1, 32'h13, 32'h000000A5, 3'b000, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'hA5ADBEEF) begin
            tests_failed++; $display("FAIL sb_lane3: got %h required a5adbeef", rd);
        end
        do_req(1'b0, 32'h13, 32'h0, 3'b000, rd, er, lat);
        tests_run++;
        if (rd !== 32'hFFFFFFA5) begin
            tests_failed++; $display("FAIL lb_sext: got %h required ffffffa5", rd);
        end
        do_req(1'b0, 32'h13, 32'h0, 3'b100, rd, er, lat);
        tests_run++;
        if (rd !== 32'h000000A5) begin
            tests_failed++; $display("FAIL lbu_zext: got %h required 000000a5", rd);
        end
        do_req(1'b0, 32'h11, 32'h0, 3'b100, rd, er, lat);
        tests_run++;
        if (rd !== 32'h000000BE) begin
            tests_failed++; $display("FAIL lbu_lane1: got %h required 000000be", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic [1:0] er; int lat;
        sel = 1'b0;
        do_req(1'b1, 32'h12, 32'h00008001, 3'b001, rd, er, lat);
        do_req(1'b0, 32'h12, 32'h0, 3'b001, rd, er, lat);
        tests_run++;
        if (rd !== 32'hFFFF8001) begin
            tests_failed++; $display("FAIL lh_sext: got %h required ffff8001", rd);
        end
        do_req(1'b0, 32'h12, 32'h0, 3'b101, rd, er, lat);
        tests_run++;
        if (rd !== 32'h00008001) begin
            tests_failed++; $display("FAIL lhu_zext: got %h required 00008001", rd);
        end
        do_req(1'b1, 32'h11, 32'h0000FFFF, 3'b001, rd, er, lat);
        tests_run++;
        if (er !== 2'b01 || rd !== 32'd0) begin
            tests_failed++; $display("FAIL sh_misal: got err=%b rdata=%h required 01/0", er, rd);
        end
        do_req(1'b0, 32'h11, 32'h0, 3'b001, rd, er, lat);
        tests_run++;
        if (er !== 2'b01 || rd !== 32'd0) begin
            tests_failed++; $display("FAIL lh_misal: got err=%b rdata=%h required 01/0", er, rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'h8001BEEF || er !== 2'b00) begin
            tests_failed++; $display("FAIL half_word_after: got %h err=%b required 8001beef/00", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] er; int lat;
        sel = 1'b1;
        do_req(1'b1, 32'h1000, 32'h11111111, 3'b010, rd, er, lat);
        tests_run++;
        if (er !== 2'b00 || lat !== 1) begin
            tests_failed++; $display("FAIL b_sw_ok: got err=%b lat=%0d required 00/1", er, lat);
        end
        do_req(1'b1, 32'h1004, 32'h33333333, 3'b010, rd, er, lat);
        do_req(1'b1, 32'h1040, 32'h22222222, 3'b010, rd, er, lat);
        tests_run++;
        if (er !== 2'b10 || rd !== 32'd0) begin
            tests_failed++; $display("FAIL oor_high: got err=%b rdata=%h required 10/0", er, rd);
        end
        do_req(1'b1, 32'h0FFC, 32'h44444444, 3'b010, rd, er, lat);
        tests_run++;
        if (er !== 2'b10) begin
            tests_failed++; $display("FAIL oor_below_base: got err=%b required 10", er);
        end
        do_req(1'b0, 32'h1000, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'h11111111 || lat !== 2 || er !== 2'b00) begin
            tests_failed++;
            $display("FAIL b_lw_no_alias: got %h lat=%0d err=%b required 11111111/2/00", rd, lat, er);
        end
        do_req(1'b0, 32'h1000, 32'h0, 3'b011, rd, er, lat);
        tests_run++;
        if (er !== 2'b11 || rd !== 32'd0) begin
            tests_failed++; $display("FAIL ld_f3_011: got err=%b rdata=%h required 11/0", er, rd);
        end
        do_req(1'b1, 32'h1000, 32'h0, 3'b100, rd, er, lat);
        tests_run++;
        if (er !== 2'b11) begin
            tests_failed++; $display("FAIL st_f3_100: got err=%b required 11", er);
        end
        do_req(1'b0, 32'h1001, 32'h0, 3'b111, rd, er, lat);
        tests_run++;
        if (er !== 2'b11) begin
            tests_failed++; $display("FAIL prio_f3_over_misal: got err=%b required 11", er);
        end
        do_req(1'b1, 32'h0FFD, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (er !== 2'b01) begin
            tests_failed++; $display("FAIL prio_misal_over_oor: got err=%b required 01", er);
        end
        do_req(1'b1, 32'h103C, 32'h5A5A5A5A, 3'b010, rd, er, lat);
        do_req(1'b0, 32'h103C, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'h5A5A5A5A || er !== 2'b00) begin
            tests_failed++; $display("FAIL last_word: got %h err=%b required 5a5a5a5a/00", rd, er);
        end
    endtask

    task automatic test_hold();
        sel = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000; req_funct3 = 3'b010;
        rsp_ready = 1'b0;
        @(posedge clk); #1 req_addr = 32'h1004;
        @(negedge clk);
        tests_run++;
        if (rsp_valid_o !== 1'b0 || dbg_o !== S_WAIT) begin
            tests_failed++;
            $display("FAIL lat2_wait: got valid=%b state=%0d required 0/1", rsp_valid_o, dbg_o);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11111111) begin
            tests_failed++;
            $display("FAIL lat2_rise: got valid=%b rdata=%h required 1/11111111", rsp_valid_o, rsp_rdata_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11111111 || rsp_err_o !== 2'b00 ||
                req_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h err=%b ready=%b required 1/11111111/00/0",
                         k, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_handshake: got valid=%b ready=%b required 0/1", rsp_valid_o, req_ready_o);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h33333333) begin
            tests_failed++;
            $display("FAIL held_req_next: got valid=%b rdata=%h required 1/33333333", rsp_valid_o, rsp_rdata_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] er; int lat;
        logic [31:0] vals [4] = '{32'h01234567, 32'h89ABCDEF, 32'hFFFF0000, 32'h0000FFFF};
        sel = 1'b0;
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 32'h20 + 32'(4 * i), vals[i], 3'b010, rd, er, lat);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'h20 + 32'(4 * i), 32'h0, 3'b010, rd, er, lat);
            tests_run++;
            if (rd !== vals[i] || lat !== 1) begin
                tests_failed++;
                $display("FAIL b2b_lw[%0d]: got %h lat=%0d required %h/1", i, rd, lat, vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] er; int lat;
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); #1 rst = 1'b0; #1;
        tests_run++;
        if (rsp_valid_o !== 1'b0 || dbg_o !== S_IDLE || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_resp: got valid=%b state=%0d ready=%b required 0/0/1",
                     rsp_valid_o, dbg_o, req_ready_o);
        end
        @(negedge clk); rst = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'h8001BEEF) begin
            tests_failed++; $display("FAIL mem_after_rst_a: got %h required 8001beef", rd);
        end
        sel = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1004; req_funct3 = 3'b010; rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        #1 rst = 1'b0; #1;
        tests_run++;
        if (rsp_valid_o !== 1'b0 || dbg_o !== S_IDLE || req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_in_wait: got valid=%b state=%0d ready=%b required 0/0/1",
                     rsp_valid_o, dbg_o, req_ready_o);
        end
        @(negedge clk); rst = 1'b1;
        do_req(1'b0, 32'h1004, 32'h0, 3'b010, rd, er, lat);
        tests_run++;
        if (rd !== 32'h33333333 || lat !== 2) begin
            tests_failed++; $display("FAIL mem_after_rst_b: got %h lat=%0d required 33333333/2", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Handshaked, parametrised successor to the core's fixed 4 KiB byte-enabled data memory. It accepts one load/store request at a time over a valid/ready request channel. It returns a response over a valid/ready response channel after a configurable read latency. It adds base-address decoding, out-of-range detection, misalignment detection and illegal-funct3 detection. It sits between the LSU and the block-RAM array, and lets the pipeline stall on memory instead of assuming a fixed negedge read.

Parameters:
WIDTH, 32, data/address width; only 32 supported.
DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
READ_LAT, 1, load latency in cycles from accept to rsp_valid; legal values 1 or 2.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_funct3  in  3  RV32I load/store funct3
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load data, sign/zero-extended; 0 for stores and errors
rsp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=00. The memory array is not cleared by reset; it is zero-initialised at time 0.
- States are IDLE, WAIT, RESP. req_ready=1 only in IDLE.
- Accept occurs when req_valid && req_ready on a rising edge. Address, we, funct3 and wdata are captured on that edge.
- Error check at accept, in priority order: illegal funct3 (loads 011/110/111; stores >010) -> 11; misaligned (H/HU/SH with addr[0]=1, W/SW with addr[1:0]!=0) -> 01; out of range ((addr-BASE_ADDR)>>2 >= DEPTH, unsigned, including addr<BASE_ADDR wrap) -> 10.
- An errored request never writes memory. It goes IDLE->RESP with rdata=0.
- Store, ok: byte-enabled write on the accept edge (SB one lane by addr[1:0]; SH lanes by addr[1]; SW all four). The other lanes are unchanged. IDLE->RESP, rsp_err=00, rdata=0.
- Load, ok: array read on the accept edge.
  - READ_LAT=1: IDLE->RESP, so rsp_valid is asserted 1 cycle after accept.
  - READ_LAT=2: IDLE->WAIT->RESP; the extracted data passes through one extra register.
  - Lane extraction and extension: LB/LBU by addr[1:0], LH/LHU by addr[1], LW whole word.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On the handshake edge go to IDLE. The next request can be accepted on the following edge, so there is no same-cycle re-accept.
- Back-to-back throughput is one request per READ_LAT+1 cycles with rsp_ready held high.
- A load issued after a store to the same word returns the new data, because the write completes before the load is accepted.
- req_valid while not ready: the request is ignored. The requester must hold it; the controller samples nothing.
- Reset mid-operation: any pending response is dropped and the state returns to IDLE. A store accepted before reset has already written and stays written.
- Address bits above the decoded range are not aliased: they fall under the out-of-range rule.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF -> rsp_valid 1 cycle after accept, err=00. LW 0x10 -> rdata=0xDEADBEEF.
- SB 0x13 wdata=0x000000A5 over 0xDEADBEEF -> LW 0x10 = 0xA5ADBEEF. LB 0x13 = 0xFFFFFFA5. LBU 0x13 = 0x000000A5.
- SH 0x12 wdata=0x00008001 -> LH 0x12 = 0xFFFF8001, LHU 0x12 = 0x00008001. LH 0x11 -> err=01, rdata=0, memory unchanged.
- BASE_ADDR=0x1000, DEPTH=16: SW 0x1040 -> err=10, no write. SW 0x0FFC -> err=10. Load funct3=011 -> err=11.
- READ_LAT=2: LW is accepted at cycle N, rsp_valid rises at N+2. Hold rsp_ready=0 for 3 cycles -> rsp_valid, rdata and err stay stable and req_ready=0. A new request is accepted only after the handshake.
- Assert rst low while in WAIT/RESP -> rsp_valid=0 immediately (async), then IDLE with req_ready=1. A prior stored word is still readable.
